// File: rtl/apb_subordinate_ni.sv
// -----------------------------------------------------------------------------
// apb_subordinate_ni
//
// APB completer-side network interface. Each APB transfer from the local
// requester is packed into a request packet and pushed to the NoC TX FIFO.
// The block then waits for the matching response packet on the RX FIFO and
// completes the APB transfer with PREADY/PRDATA/PSLVERR. Transfers are
// non-posted and single-outstanding; writes also wait for their response.
//
// Optional build macro:
//   APB_SUB_TIMEOUT_EN - bound the response wait to TIMEOUT_CYCLES. On expiry
//                        the transfer ends with PSLVERR=1 and the late
//                        response is popped and dropped later from idle.
//
// Ports:
//   PCLK             clock
//   PRESETn          synchronous active-low reset
//   in_apb_sigs      PADDR/PSELx/PENABLE/PWRITE/PWDATA from the requester
//   op_apb_sigs      PREADY/PRDATA/PSLVERR to the requester
//   out_req_pkt      request packet to the TX FIFO
//   req_fifo_full    TX FIFO full
//   req_fifo_wreq    TX FIFO write strobe (single-cycle pulse)
//   in_resp_pkt      response packet, valid the cycle after resp_fifo_rreq
//   resp_fifo_empty  RX FIFO empty
//   resp_fifo_rreq   RX FIFO read strobe (single-cycle pulse)
//
// Packet body layout (15-bit data_bits per flit):
//   request : flit0 = {PADDR[13:0], PWRITE}
//             {flit1, flit2, flit3[14:13]} = PWDATA (0 for reads)
//   response: {flit1, flit2, flit3[14:13]} = PRDATA, flit3[0] = error
// -----------------------------------------------------------------------------

package apb_ni_pkg;

  localparam int APB_ADDR_W     = 14;
  localparam int APB_DATA_W     = 32;
  localparam int FLIT_DATA_W    = 15;
  localparam int NUM_BODY_FLITS = 4;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] PADDR;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_DATA_W-1:0] PWDATA;
  } apb_req_s;

  typedef struct packed {
    logic                  PREADY;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PSLVERR;
  } apb_resp_s;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data_bits;
  } flit_s;

  typedef struct packed {
    flit_s [NUM_BODY_FLITS-1:0] body_flit;
  } req_packet_s;

  typedef struct packed {
    flit_s [NUM_BODY_FLITS-1:0] body_flit;
  } resp_packet_s;

endpackage

module apb_subordinate_ni
  import apb_ni_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  apb_req_s     in_apb_sigs,
  output apb_resp_s    op_apb_sigs,
  output req_packet_s  out_req_pkt,
  input  logic         req_fifo_full,
  output logic         req_fifo_wreq,
  input  resp_packet_s in_resp_pkt,
  input  logic         resp_fifo_empty,
  output logic         resp_fifo_rreq
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    SUB_IDLE_ST,
    SUB_REQ_ST,
    SUB_RESP_WAIT_ST,
    SUB_RESP_LATCH_ST,
    SUB_DONE_ST
  } sub_state_e;

  sub_state_e          state_q, state_d;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                pslverr_q;

  logic                setup_seen;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

  // Fields of the response packet that carry nothing for this block.
  logic                resp_unused;
  assign resp_unused = ^{in_resp_pkt.body_flit[0].data_bits,
                         in_resp_pkt.body_flit[3].data_bits[12:1]};

  assign setup_seen = in_apb_sigs.PSELx && !in_apb_sigs.PENABLE;
  assign rsp_data   = {in_resp_pkt.body_flit[1].data_bits,
                       in_resp_pkt.body_flit[2].data_bits,
                       in_resp_pkt.body_flit[3].data_bits[14:13]};
  assign rsp_err    = in_resp_pkt.body_flit[3].data_bits[0];

`ifdef APB_SUB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             drop_pending_q;  // a timed-out response is still owed
  logic             timeout_hit;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and FIFO strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    req_fifo_wreq  = 1'b0;
    resp_fifo_rreq = 1'b0;
`ifdef APB_SUB_TIMEOUT_EN
    timeout_hit    = 1'b0;
`endif

    unique case (state_q)
      SUB_IDLE_ST: begin
        if (setup_seen) state_d = SUB_REQ_ST;
`ifdef APB_SUB_TIMEOUT_EN
        // Drain the response of an earlier timed-out transfer.
        if (drop_pending_q && !resp_fifo_empty) resp_fifo_rreq = 1'b1;
`endif
      end
      SUB_REQ_ST: begin
        if (!req_fifo_full) begin
          req_fifo_wreq = 1'b1;
          state_d       = SUB_RESP_WAIT_ST;
        end
      end
      SUB_RESP_WAIT_ST: begin
        if (!resp_fifo_empty) begin
          resp_fifo_rreq = 1'b1;
          state_d        = SUB_RESP_LATCH_ST;
        end
`ifdef APB_SUB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = SUB_DONE_ST;
        end
`endif
      end
      SUB_RESP_LATCH_ST: state_d = SUB_DONE_ST;
      SUB_DONE_ST:       state_d = SUB_IDLE_ST;
      default:           state_d = SUB_IDLE_ST;
    endcase

    // The reset is synchronous, so the state is still live during the reset
    // cycle; gate the strobes so nothing is pushed or popped while held.
    if (!PRESETn) begin
      req_fifo_wreq  = 1'b0;
      resp_fifo_rreq = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and transfer registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge PCLK) begin
    // NOTE: every register here is plain flops (no memory array), so all of
    // them are cleared by reset; nothing stale survives an aborted transfer.
    if (!PRESETn) begin
      state_q   <= SUB_IDLE_ST;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == SUB_IDLE_ST && setup_seen) begin
        pwrite_q <= in_apb_sigs.PWRITE;
        paddr_q  <= in_apb_sigs.PADDR;
        pwdata_q <= in_apb_sigs.PWRITE ? in_apb_sigs.PWDATA : '0;
      end

      if (state_q == SUB_RESP_LATCH_ST) begin
        prdata_q  <= pwrite_q ? '0 : rsp_data;
        pslverr_q <= rsp_err;
      end
`ifdef APB_SUB_TIMEOUT_EN
      else if (timeout_hit) begin
        prdata_q  <= '0;
        pslverr_q <= 1'b1;
      end
`endif
    end
  end

`ifdef APB_SUB_TIMEOUT_EN
  // Wait counter runs only in SUB_RESP_WAIT_ST and is zero on entry.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_cnt_q     <= '0;
      drop_pending_q <= 1'b0;
    end else begin
      if (state_q == SUB_RESP_WAIT_ST) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                             wait_cnt_q <= '0;

      if (timeout_hit)
        drop_pending_q <= 1'b1;
      else if (state_q == SUB_IDLE_ST && drop_pending_q && !resp_fifo_empty)
        drop_pending_q <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    op_apb_sigs = '0;
    if (state_q == SUB_DONE_ST) begin
      op_apb_sigs.PREADY  = 1'b1;
      op_apb_sigs.PRDATA  = prdata_q;
      op_apb_sigs.PSLVERR = pslverr_q;
    end
  end

  // The packet is a pure function of the latched fields, so it stays stable
  // from SUB_REQ_ST through SUB_DONE_ST whatever the requester does.
  always_comb begin
    out_req_pkt = '0;
    out_req_pkt.body_flit[0].data_bits       = {paddr_q[13:0], pwrite_q};
    out_req_pkt.body_flit[1].data_bits       = pwdata_q[31:17];
    out_req_pkt.body_flit[2].data_bits       = pwdata_q[16:2];
    out_req_pkt.body_flit[3].data_bits[14:13] = pwdata_q[1:0];
  end

endmodule

// File: tb/tb_apb_subordinate_ni.sv
// -----------------------------------------------------------------------------
// tb_apb_subordinate_ni
//
// Drives the APB side of apb_subordinate_ni and models both NoC FIFOs plus a
// responder. Expected packets, read data, error and latency come from the
// packet map and the latency rule (4 cycles + stall cycles), not from the
// DUT's internals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_apb_subordinate_ni;
  import apb_ni_pkg::*;

  localparam int TO_CYC = 8;

  logic         PCLK;
  logic         PRESETn;
  apb_req_s     apb_in;
  apb_resp_s    apb_out;
  req_packet_s  req_pkt;
  logic         full;
  logic         wreq;
  resp_packet_s rsp_pkt;
  logic         empty;
  logic         rreq;

  apb_subordinate_ni #(
    .ADDR_W        (14),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .in_apb_sigs    (apb_in),
    .op_apb_sigs    (apb_out),
    .out_req_pkt    (req_pkt),
    .req_fifo_full  (full),
    .req_fifo_wreq  (wreq),
    .in_resp_pkt    (rsp_pkt),
    .resp_fifo_empty(empty),
    .resp_fifo_rreq (rreq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------------------------------------------------------------------
  // Bookkeeping and environment model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  resp_packet_s rx_q[$];        // RX FIFO contents
  resp_packet_s popped;         // packet presented the cycle after a read
  bit           rreq_prev;
  bit           rsp_armed;      // responder answers the next request
  resp_packet_s rsp_next;
  int           rsp_delay;
  bit           pend_valid;
  int           pend_cnt;
  resp_packet_s pend_pkt;
  int           full_cnt;
  int           wreq_cnt, rreq_cnt;
  int           cyc, wreq_cyc, t0_cyc;
  req_packet_s  last_tx;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // PWDATA occupies the 32 MSBs of the 45-bit span flit1..flit3.
  function automatic req_packet_s make_req(input logic w, input logic [13:0] a,
                                           input logic [31:0] wd);
    logic [44:0] body;
    req_packet_s p;
    body = {13'd0, (w ? wd : 32'd0)} << 13;
    p = '0;
    p.body_flit[0].data_bits = 15'(a) * 15'd2 + 15'(w);
    p.body_flit[1].data_bits = body[44:30];
    p.body_flit[2].data_bits = body[29:15];
    p.body_flit[3].data_bits = body[14:0];
    return p;
  endfunction

  // Response with random filler in every field the block must ignore.
  function automatic resp_packet_s make_rsp(input logic [31:0] rd, input logic er);
    logic [44:0] body;
    resp_packet_s p;
    body = ({13'd0, rd} << 13) | 45'(er) | (45'($urandom_range(0, 4095)) << 1);
    p.body_flit[0].data_bits = 15'($urandom);
    p.body_flit[1].data_bits = body[44:30];
    p.body_flit[2].data_bits = body[29:15];
    p.body_flit[3].data_bits = body[14:0];
    return p;
  endfunction

  // One clock: apply FIFO-side inputs at +1, sample strobes at +2.
  task automatic cycle();
    logic [63:0] junk;
    @(posedge PCLK);
    #1;
    cyc++;
    full = (full_cnt > 0);
    if (full_cnt > 0) full_cnt--;
    if (pend_valid) begin
      if (pend_cnt == 0) begin
        rx_q.push_back(pend_pkt);
        pend_valid = 1'b0;
      end else pend_cnt--;
    end
    empty = (rx_q.size() == 0);
    junk  = {$urandom, $urandom};
    rsp_pkt = rreq_prev ? popped : resp_packet_s'(junk[59:0]);
    #1;
    rreq_prev = 1'b0;
    if (wreq === 1'b1) begin
      wreq_cnt++;
      wreq_cyc = cyc;
      last_tx  = req_pkt;
      if (rsp_armed) begin
        pend_valid = 1'b1;
        pend_cnt   = rsp_delay;
        pend_pkt   = rsp_next;
        rsp_armed  = 1'b0;
      end
    end
    if (rreq === 1'b1) begin
      rreq_cnt++;
      if (rx_q.size() > 0) popped = rx_q.pop_front();
      rreq_prev = 1'b1;
    end
  endtask

  // Full APB transfer; lat counts cycles from the setup cycle to PREADY.
  task automatic xfer(input logic w, input logic [13:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic er, input int nfull,
                      input int dly, input bit respond,
                      output int lat, output logic [31:0] prd, output logic perr);
    bit done;
    cycle();
    t0_cyc         = cyc;
    apb_in.PADDR   = a;
    apb_in.PSELx   = 1'b1;
    apb_in.PENABLE = 1'b0;
    apb_in.PWRITE  = w;
    apb_in.PWDATA  = wd;
    full_cnt  = nfull;
    rsp_armed = respond;
    rsp_next  = make_rsp(rd, er);
    rsp_delay = dly;
    wreq_cnt  = 0;
    rreq_cnt  = 0;
    lat  = 0;
    done = 1'b0;
    prd  = '0;
    perr = 1'b0;
    while (!done && lat < 300) begin
      cycle();
      lat++;
      if (apb_out.PREADY === 1'b1) begin
        done   = 1'b1;
        prd    = apb_out.PRDATA;
        perr   = apb_out.PSLVERR;
        apb_in = '0;
      end else begin
        // Access phase; the address/data lines wander to prove they are
        // not sampled again after setup.
        apb_in.PENABLE = 1'b1;
        apb_in.PADDR   = 14'($urandom);
        apb_in.PWDATA  = $urandom;
        apb_in.PWRITE  = 1'($urandom);
      end
    end
    check("pready_seen", 64'(done), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          lat, lat2;
    logic [31:0] prd, prd2;
    logic        perr, perr2;
    req_packet_s exp_pkt;

    PRESETn    = 1'b0;
    apb_in     = '0;
    full       = 1'b0;
    empty      = 1'b1;
    rsp_pkt    = '0;
    rreq_prev  = 1'b0;
    rsp_armed  = 1'b0;
    pend_valid = 1'b0;
    full_cnt   = 0;
    cyc        = 0;
    wreq_cyc   = 0;

    // Reset state
    repeat (3) cycle();
    check("rst_apb_out", 64'(apb_out), 64'd0);
    check("rst_req_pkt", 64'(req_pkt), 64'd0);
    check("rst_wreq",    64'(wreq),    64'd0);
    check("rst_rreq",    64'(rreq),    64'd0);
    PRESETn = 1'b1;

    // Read 0x0123 -> 0xDEADBEEF, minimum latency
    xfer(1'b0, 14'h0123, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1, lat, prd, perr);
    exp_pkt = make_req(1'b0, 14'h0123, 32'h0);
    check("rd_flit0",    64'(last_tx.body_flit[0].data_bits), 64'h0246);
    check("rd_pkt",      64'(last_tx), 64'(exp_pkt));
    check("rd_pkt_held", 64'(req_pkt), 64'(exp_pkt));
    check("rd_latency",  64'(lat), 64'd4);
    check("rd_prdata",   64'(prd), 64'hDEAD_BEEF);
    check("rd_pslverr",  64'(perr), 64'd0);
    check("rd_wreq_cnt", 64'(wreq_cnt), 64'd1);
    check("rd_rreq_cnt", 64'(rreq_cnt), 64'd1);

    // Write 0x3FFF / 0xA5A50F0F, error response
    xfer(1'b1, 14'h3FFF, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b1, lat, prd, perr);
    exp_pkt = make_req(1'b1, 14'h3FFF, 32'hA5A5_0F0F);
    check("wr_flit0",   64'(last_tx.body_flit[0].data_bits), 64'h7FFF);
    check("wr_flit1",   64'(last_tx.body_flit[1].data_bits), 64'(exp_pkt.body_flit[1].data_bits));
    check("wr_flit2",   64'(last_tx.body_flit[2].data_bits), 64'(exp_pkt.body_flit[2].data_bits));
    check("wr_flit3",   64'(last_tx.body_flit[3].data_bits), 64'(exp_pkt.body_flit[3].data_bits));
    check("wr_prdata",  64'(prd), 64'd0);
    check("wr_pslverr", 64'(perr), 64'd1);

    // TX FIFO full for 5 cycles after setup
    xfer(1'b0, 14'h0AAA, 32'h0, 32'h0BAD_CAFE, 1'b0, 5, 0, 1'b1, lat, prd, perr);
    check("full_wreq_cyc", 64'(wreq_cyc - t0_cyc), 64'd6);
    check("full_wreq_cnt", 64'(wreq_cnt), 64'd1);
    check("full_latency",  64'(lat), 64'd9);
    check("full_prdata",   64'(prd), 64'h0BAD_CAFE);

    // Back-to-back reads, second setup right after the first PREADY
    xfer(1'b0, 14'h0010, 32'h0, 32'h1111_2222, 1'b0, 0, 0, 1'b1, lat, prd, perr);
    lat2 = wreq_cnt + rreq_cnt;
    xfer(1'b0, 14'h0020, 32'h0, 32'h3333_4444, 1'b0, 0, 0, 1'b1, lat, prd2, perr2);
    check("b2b_strobes", 64'(lat2 + wreq_cnt + rreq_cnt), 64'd4);
    check("b2b_prdata0", 64'(prd),  64'h1111_2222);
    check("b2b_prdata1", 64'(prd2), 64'h3333_4444);
    check("b2b_latency", 64'(lat),  64'd4);

    // Reset while waiting for the response
    cycle();
    apb_in.PADDR = 14'h0055; apb_in.PSELx = 1'b1; apb_in.PWRITE = 1'b0;
    rsp_armed = 1'b1; rsp_next = make_rsp(32'h5555_5555, 1'b0); rsp_delay = 50;
    repeat (3) begin
      cycle();
      apb_in.PENABLE = 1'b1;
    end
    PRESETn = 1'b0;
    rx_q.push_back(make_rsp(32'h7777_7777, 1'b0));
    empty = 1'b0;
    #1;
    check("rst_gates_rreq", 64'(rreq), 64'd0);
    cycle();
    check("rst_mid_apb_out", 64'(apb_out), 64'd0);
    check("rst_mid_req_pkt", 64'(req_pkt), 64'd0);
    check("rst_mid_strobes", 64'({wreq, rreq}), 64'd0);
    cycle();
    // System reset flushes both FIFOs.
    rx_q.delete();
    pend_valid = 1'b0; rsp_armed = 1'b0; rreq_prev = 1'b0;
    empty = 1'b1; apb_in = '0;
    PRESETn = 1'b1;
    xfer(1'b0, 14'h0101, 32'h0, 32'hC0DE_F00D, 1'b0, 0, 0, 1'b1, lat, prd, perr);
    check("post_rst_prdata",  64'(prd), 64'hC0DE_F00D);
    check("post_rst_latency", 64'(lat), 64'd4);

    // Randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      logic        w, er;
      logic [13:0] a;
      logic [31:0] wd, rd;
      int          nf, dl, gap;
      w  = 1'($urandom);
      er = 1'($urandom);
      a  = 14'($urandom);
      wd = $urandom;
      rd = $urandom;
      nf = $urandom_range(0, 3);
      dl = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      xfer(w, a, wd, rd, er, nf, dl, 1'b1, lat, prd, perr);
      check("rnd_pkt",      64'(last_tx), 64'(make_req(w, a, wd)));
      check("rnd_latency",  64'(lat), 64'(4 + nf + dl));
      check("rnd_prdata",   64'(prd), 64'(w ? 32'd0 : rd));
      check("rnd_pslverr",  64'(perr), 64'(er));
      check("rnd_strobes",  64'({wreq_cnt[7:0], rreq_cnt[7:0]}), 64'h0101);
      repeat (gap) cycle();
    end

`ifdef APB_SUB_TIMEOUT_EN
    // No response: PSLVERR eight cycles after the wait starts
    xfer(1'b0, 14'h0042, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, lat, prd, perr);
    check("to_latency", 64'(lat), 64'(2 + TO_CYC));
    check("to_pslverr", 64'(perr), 64'd1);
    check("to_prdata",  64'(prd), 64'd0);
    check("to_rreq",    64'(rreq_cnt), 64'd0);
    // Late response is popped from idle and dropped
    cycle();
    rx_q.push_back(make_rsp(32'hBADB_AD00, 1'b0));
    rreq_cnt = 0;
    repeat (3) cycle();
    check("to_drop_rreq",  64'(rreq_cnt), 64'd1);
    check("to_drop_empty", 64'(rx_q.size()), 64'd0);
    xfer(1'b0, 14'h0043, 32'h0, 32'h600D_DA7A, 1'b0, 0, 0, 1'b1, lat, prd, perr);
    check("to_next_prdata", 64'(prd), 64'h600D_DA7A);
    check("to_next_rreq",   64'(rreq_cnt), 64'd1);
`endif

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_subordinate_ni.md
Name: apb_subordinate_ni

Overview:
APB completer-side network interface. It accepts APB transfers from a local APB requester and packs each one into a request packet pushed to the NoC TX FIFO. It then waits for the matching response packet on the RX FIFO and completes the APB transfer with PRDATA/PSLVERR. It sits opposite the APB manager NI: this block originates request packets and consumes response packets. Transfers are non-posted and single-outstanding; writes also wait for a response.

Parameters:
ADDR_W, 14, APB address width carried in the packet
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 256, response wait limit (used only with APB_SUB_TIMEOUT_EN)

Ports:
PCLK  input  1  clock
PRESETn  input  1  reset; synchronous, active-low
in_apb_sigs  input  apb_req_s  PADDR/PSELx/PENABLE/PWRITE/PWDATA from local requester
op_apb_sigs  output  apb_resp_s  PREADY/PRDATA/PSLVERR to local requester
out_req_pkt  output  req_packet_s  request packet to TX FIFO
req_fifo_full  input  1  TX FIFO full; no write while high
req_fifo_wreq  output  1  TX FIFO write strobe
in_resp_pkt  input  resp_packet_s  response packet from RX FIFO, valid one cycle after rreq
resp_fifo_empty  input  1  RX FIFO empty
resp_fifo_rreq  output  1  RX FIFO read strobe

Behaviour:
- Packet map, request: body_flit[0].data_bits[0]=PWRITE; body_flit[0].data_bits[14:1]=PADDR[13:0]; {body_flit[1].data_bits, body_flit[2].data_bits, body_flit[3].data_bits[14:13]}=PWDATA (MSB first). For reads, the PWDATA field is 0. All other bits are 0.
- Packet map, response: PRDATA={body_flit[1].data_bits, body_flit[2].data_bits, body_flit[3].data_bits[14:13]}; error flag=body_flit[3].data_bits[0].
- Registered state, local enum:
  - SUB_IDLE_ST: wait for PSELx=1 and PENABLE=0. On that edge, latch PADDR/PWRITE/PWDATA, then go to SUB_REQ_ST.
  - SUB_REQ_ST: out_req_pkt is driven from the latched fields. If !req_fifo_full, req_fifo_wreq=1 for this cycle and go to SUB_RESP_WAIT_ST; otherwise stay.
  - SUB_RESP_WAIT_ST: if !resp_fifo_empty, resp_fifo_rreq=1 for this cycle and go to SUB_RESP_LATCH_ST; otherwise stay.
  - SUB_RESP_LATCH_ST: capture in_resp_pkt. PRDATA reg = decoded data if the latched PWRITE=0, else 0. PSLVERR reg = error flag. Go to SUB_DONE_ST.
  - SUB_DONE_ST: PREADY=1, PRDATA/PSLVERR driven from regs, then go to SUB_IDLE_ST.
- Outside SUB_DONE_ST: PREADY=0, PRDATA=0, PSLVERR=0.
- Minimum latency, with TX not full and RX already non-empty: setup cycle T0, wreq T1, rreq T2, latch T3, PREADY T4. Every full or empty stall adds one cycle per cycle held.
- req_fifo_wreq and resp_fifo_rreq are single-cycle pulses, at most one each per transfer.
- The latched request fields are held stable from SUB_REQ_ST through SUB_DONE_ST, independent of in_apb_sigs.
- Back-to-back: a new setup phase in the cycle after PREADY is accepted from SUB_IDLE_ST with no bubble beyond that.
- PSELx deasserted mid-transfer (protocol violation): the FSM still completes the FIFO handshakes and drains exactly one response, so the FIFOs stay aligned. PREADY pulses in SUB_DONE_ST regardless.
- A setup phase that arrives while the FSM is not in SUB_IDLE_ST is ignored. The APB requester does not issue one, because it cannot before PREADY.
- Reset (PRESETn=0 at a PCLK edge, including mid-transfer):
  - state goes to SUB_IDLE_ST and all latched regs are cleared to 0;
  - PREADY, PRDATA, PSLVERR, req_fifo_wreq, resp_fifo_rreq are 0 and out_req_pkt='0 the next cycle;
  - no FIFO strobe is issued while PRESETn=0;
  - a response that arrives after an aborted transfer is not discarded by this block; system reset flushes the FIFOs.

Optional Feature:
APB_SUB_TIMEOUT_EN
- Defined: a counter clears on entry to SUB_RESP_WAIT_ST and increments each cycle spent there. When it reaches TIMEOUT_CYCLES-1 with resp_fifo_empty still high, the FSM goes to SUB_DONE_ST with PSLVERR=1 and PRDATA=0, and no rreq is issued. A sticky internal flag then makes the next response packet be read and dropped: rreq is issued from SUB_IDLE_ST when !resp_fifo_empty, and the flag clears on that read. Reset clears the counter and the flag.
- Undefined: the block waits indefinitely; there is no counter and no flag.

Test Plan:
- Read PADDR=0x0123, responder returns PRDATA=0xDEADBEEF, error 0 -> out_req_pkt flit0 data_bits=0x0246; PREADY=1 at T4 with PRDATA=0xDEADBEEF, PSLVERR=0.
- Write PADDR=0x3FFF, PWDATA=0xA5A5_0F0F -> flit0 data_bits=0x7FFF, PWDATA mapping checked across flits 1–3; response error=1 -> PSLVERR=1, PRDATA=0.
- req_fifo_full held high 5 cycles after setup -> no wreq during the stall; wreq pulses once in the first non-full cycle; PREADY at T9.
- Two back-to-back reads, with the second setup in the cycle after the first PREADY -> exactly 2 wreq and 2 rreq; correct PRDATA for each.
- PRESETn asserted in SUB_RESP_WAIT_ST -> all outputs 0 the next cycle; a fresh read afterwards completes normally.
- APB_SUB_TIMEOUT_EN, TIMEOUT_CYCLES=8, RX stays empty -> PSLVERR=1 eight cycles after the wait starts; a late response is then popped and dropped; the next transfer receives its own data.
